// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : console_pkg
//  Description : Shared constants, control codes and state type for the
//                text_console character-stream front end.
//  Revision    : 1.0  initial release
// ============================================================================
package console_pkg;

    localparam int COLS = 64;
    localparam int ROWS = 4;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Control codes interpreted by the console; everything else that is not
    // printable is consumed and dropped.
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        CLEAR  = 2'd2
    } console_state_t;

    function automatic logic isPrintable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
//  Module      : text_console
//  Description : Accepts ASCII bytes over valid/ready, interprets BS/LF/FF/CR,
//                and maintains the 4x64 character buffer and cursor that feed
//                the Pixels renderer. Scroll and clear are 256-cycle walks
//                over the buffer, during which input is stalled.
//  Ports       : clk        - system clock (renderer domain)
//                rst        - asynchronous active-high reset
//                in_valid   - in_data holds a byte to consume
//                in_data    - ASCII byte
//                in_ready   - byte can be accepted this cycle (state == IDLE)
//                text       - character buffer, index = row*COLS + col
//                cursor_pos - buffer index of the next write
//                busy       - scroll or clear in progress (== !in_ready)
//  Revision    : 1.0  initial release
// ============================================================================
module text_console
    import console_pkg::*;
#(
    parameter int COLS = 64,
    parameter int ROWS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] text [COLS*ROWS-1:0],
    output logic [7:0] cursor_pos,
    output logic       busy
);

    localparam logic [7:0] c_LAST_IDX  = 8'(COLS*ROWS - 1);
    localparam logic [7:0] c_LAST_ROW0 = 8'(COLS*(ROWS - 1));  // first index of bottom row
    localparam logic [7:0] c_COLS8     = 8'(COLS);
    localparam logic [1:0] c_LAST_ROW  = 2'(ROWS - 1);

    console_state_t r_state;
    logic [7:0]     r_idx;
    logic [7:0]     w_srcIdx;
    logic [1:0]     w_row;

    // Source of a scroll copy. Wraps for the bottom row, but those entries
    // are blanked instead of copied, so the wrapped value is never used.
    assign w_srcIdx = r_idx + c_COLS8;
    assign w_row    = cursor_pos[7:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COLS*ROWS; i++) begin
                text[i] <= CHAR_SPACE;
            end
            cursor_pos <= 8'd0;
            r_state    <= IDLE;
            r_idx      <= 8'd0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (isPrintable(in_data)) begin
                            text[cursor_pos] <= in_data;
                            if (cursor_pos == c_LAST_IDX) begin
                                // Cursor shows its post-scroll home immediately.
                                r_state    <= SCROLL;
                                cursor_pos <= c_LAST_ROW0;
                                in_ready   <= 1'b0;
                                busy       <= 1'b1;
                            end else begin
                                cursor_pos <= cursor_pos + 8'd1;
                            end
                        end else begin
                            case (in_data)
                                CC_LF: begin
                                    if (w_row == c_LAST_ROW) begin
                                        r_state    <= SCROLL;
                                        cursor_pos <= c_LAST_ROW0;
                                        in_ready   <= 1'b0;
                                        busy       <= 1'b1;
                                    end else begin
                                        cursor_pos <= {w_row + 2'd1, 6'd0};
                                    end
                                end
                                CC_CR: begin
                                    cursor_pos <= {w_row, 6'd0};
                                end
                                CC_BS: begin
                                    if (cursor_pos != 8'd0) begin
                                        cursor_pos                 <= cursor_pos - 8'd1;
                                        text[cursor_pos - 8'd1]    <= CHAR_SPACE;
                                    end
                                end
                                CC_FF: begin
                                    r_state    <= CLEAR;
                                    cursor_pos <= 8'd0;
                                    in_ready   <= 1'b0;
                                    busy       <= 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                SCROLL: begin
                    // Ascending walk: entry idx+COLS has not been overwritten yet.
                    if (r_idx < c_LAST_ROW0) begin
                        text[r_idx] <= text[w_srcIdx];
                    end else begin
                        text[r_idx] <= CHAR_SPACE;
                    end
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state  <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                CLEAR: begin
                    text[r_idx] <= CHAR_SPACE;
                    r_idx       <= r_idx + 8'd1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state  <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_idx    <= 8'd0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
